writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//   Parametrised write-back stage that retires MEM/WB instructions. Drives the
//   register-file write port and pushes OUT-instruction data into a buffered
//   output-port FIFO with a valid/ready handshake. Replaces the tristated output
//   port with a registered, stallable path.
//   Sits between the MEM/WB pipeline register, the register file and the output device.
// PARAMETERS
//   DATA_W     16  register / port data width
//   ADDR_W     3   register address width
//   CTRL_W     3   control-bundle width; bit indices come from wb_pkg
//   OUT_DEPTH  4   output FIFO entries; power of 2, >= 2
// PORTS
//   clk             in   1               single clock, all state updates on rising edge
//   rst             in   1               synchronous, active-high reset
//   wb_valid_in     in   1               MEM/WB holds a live instruction
//   ctrl_in         in   CTRL_W          [0]=reg_write, [1]=out_en, [2]=reserved (ignored)
//   data_in         in   DATA_W          result to retire
//   addr_in         in   ADDR_W          destination register
//   reg_write       out  1               register-file write enable
//   write_data      out  DATA_W          = data_in
//   write_addr      out  ADDR_W          = addr_in
//   wb_stall        out  1               hold MEM/WB and upstream stages this cycle
//   out_port_data   out  DATA_W          FIFO head
//   out_port_valid  out  1               FIFO non-empty
//   out_port_ready  in   1               device accepts head this cycle
//   out_port_last   out  DATA_W          sticky copy of the last accepted OUT value
//   out_count       out  $clog2(OUT_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//   - accept = wb_valid_in & !wb_stall. An instruction retires only in its accept cycle.
//   - wb_stall = wb_valid_in & ctrl_in[1] & fifo_full. Combinational. No push bypass when
//     full, even if a pop happens in the same cycle.
//   - reg_write = accept & ctrl_in[0]. Combinational, same cycle as the MEM/WB outputs.
//     It is forced low while stalled.
//   - push = accept & ctrl_in[1]. pop = out_port_valid & out_port_ready.
//   - Push latency: data written at edge N is visible on out_port_data and out_port_valid
//     after edge N. There is no fall-through.
//   - Push and pop in the same cycle: both take effect and out_count is unchanged.
//     Pop on an empty FIFO is impossible because valid is low.
//   - Read and write pointers are $clog2(OUT_DEPTH) bits wide and wrap modulo OUT_DEPTH.
//     full = (count == OUT_DEPTH); empty = (count == 0).
//   - out_port_last loads data_in on every push and holds otherwise.
//   - An instruction with both reg_write and out_en does both actions in the same accept cycle.
//   - wb_valid_in = 0: no write, no push, no stall. Control bits are don't-care.
//   - Reset: pointers = 0, out_count = 0, out_port_valid = 0, out_port_last = 0. FIFO
//     contents are discarded, including any in-flight entries.
//     reg_write = 0 while rst is high. wb_stall = 0 while rst is high.
//   - out_port_data is undefined while out_port_valid = 0. The bench must not check it then.
// STRUCTURE
//   - wb_pkg holds: CTRL_REG_WRITE = 0, CTRL_OUT_EN = 1, CTRL_RSVD = 2, and the default
//     DATA_W / ADDR_W localparams shared with the register file and the MEM/WB register.
//   - Sub-module wb_out_fifo (parametrised DATA_W, OUT_DEPTH; push, pop, full, empty, count).
//   - Top level contains the accept/stall logic and the out_port_last register.
// TESTING
//   1. Reset: assert rst mid-stream with 3 entries queued.
//      -> next cycle out_count=0, valid=0, last=0, reg_write=0.
//   2. ALU writeback: valid=1, ctrl=3'b001, data=16'hBEEF, addr=3'd5.
//      -> reg_write=1, write_addr=5, write_data=BEEF same cycle, no push.
//   3. OUT burst with ready=0: 4 OUT instructions 0x0001..0x0004.
//      -> count reaches 4. A 5th OUT instruction gives wb_stall=1 and reg_write=0.
//      -> Raise ready one cycle: head 0x0001 pops; 5th is accepted on the following cycle.
//   4. Simultaneous push/pop at count=2 with ready=1.
//      -> count stays 2; ordering 1,2,3 preserved across pointer wrap (run >= 2*OUT_DEPTH items).
//   5. Combined ctrl=3'b011, data=16'h00A5, addr=3'd2.
//      -> reg_write=1 and push in the same cycle; out_port_last=00A5 next cycle.
//   6. Invalid slot: wb_valid_in=0, ctrl=3'b011, FIFO full.
//      -> reg_write=0, wb_stall=0, count unchanged.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: control-bundle bit positions
// and the default datapath widths used by the register file and MEM/WB register.
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 3;
    localparam int WB_CTRL_W = 3;

    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_OUT_EN    = 1;
    localparam int CTRL_RSVD      = 2;

endpackage

// File: rtl/wb_out_fifo.sv
// Output-port FIFO: registered head, no fall-through, power-of-two depth with
// wrapping pointers and an explicit occupancy counter for full/empty.
module wb_out_fifo #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_W-1:0]            push_data,
    output logic [DATA_W-1:0]            head_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(OUT_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full      = (count_q == CNT_W'(OUT_DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Next pointer/occupancy; a push against a full FIFO is dropped, never bypassed.
    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: reset discards all queued entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: retires MEM/WB instructions into the register file and
// queues OUT values for the output device, stalling upstream when the queue is full.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_W    = WB_DATA_W,
    parameter int ADDR_W    = WB_ADDR_W,
    parameter int CTRL_W    = WB_CTRL_W,
    parameter int OUT_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_valid_in,
    input  logic [CTRL_W-1:0]            ctrl_in,
    input  logic [DATA_W-1:0]            data_in,
    input  logic [ADDR_W-1:0]            addr_in,
    output logic                         reg_write,
    output logic [DATA_W-1:0]            write_data,
    output logic [ADDR_W-1:0]            write_addr,
    output logic                         wb_stall,
    output logic [DATA_W-1:0]            out_port_data,
    output logic                         out_port_valid,
    input  logic                         out_port_ready,
    output logic [DATA_W-1:0]            out_port_last,
    output logic [$clog2(OUT_DEPTH):0]   out_count
);

    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] last_q, last_d;
    logic              unused_rsvd;

    // The reserved control bit carries no meaning in this stage.
    assign unused_rsvd = ctrl_in[CTRL_RSVD];

    assign write_data     = data_in;
    assign write_addr     = addr_in;
    assign out_port_valid = ~fifo_empty;
    assign out_port_last  = last_q;

    // Accept/stall decode; nothing retires and nothing stalls while in reset.
    always_comb begin
        wb_stall  = wb_valid_in & ctrl_in[CTRL_OUT_EN] & fifo_full & ~rst;
        accept    = wb_valid_in & ~wb_stall & ~rst;
        reg_write = accept & ctrl_in[CTRL_REG_WRITE];
        push      = accept & ctrl_in[CTRL_OUT_EN];
        pop       = out_port_valid & out_port_ready;
        last_d    = push ? data_in : last_q;
    end

    // Sticky copy of the most recently queued OUT value.
    always_ff @(posedge clk) begin
        if (rst) last_q <= '0;
        else     last_q <= last_d;
    end

    wb_out_fifo #(
        .DATA_W    (DATA_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (data_in),
        .head_data (out_port_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (out_count)
    );

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: inputs change 1ns after the rising edge,
// outputs are sampled 2ns later, well away from the next edge.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid_in;
    logic [2:0]  ctrl_in;
    logic [15:0] data_in;
    logic [2:0]  addr_in;
    logic        reg_write;
    logic [15:0] write_data;
    logic [2:0]  write_addr;
    logic        wb_stall;
    logic [15:0] out_port_data;
    logic        out_port_valid;
    logic        out_port_ready;
    logic [15:0] out_port_last;
    logic [2:0]  out_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    writeback_unit #(
        .DATA_W    (16),
        .ADDR_W    (3),
        .CTRL_W    (3),
        .OUT_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid_in    (wb_valid_in),
        .ctrl_in        (ctrl_in),
        .data_in        (data_in),
        .addr_in        (addr_in),
        .reg_write      (reg_write),
        .write_data     (write_data),
        .write_addr     (write_addr),
        .wb_stall       (wb_stall),
        .out_port_data  (out_port_data),
        .out_port_valid (out_port_valid),
        .out_port_ready (out_port_ready),
        .out_port_last  (out_port_last),
        .out_count      (out_count)
    );

    // Apply inputs, then let combinational outputs settle before sampling.
    task automatic drive(input logic v, input logic [2:0] c, input logic [15:0] d,
                         input logic [2:0] a, input logic rdy);
        wb_valid_in    = v;
        ctrl_in        = c;
        data_in        = d;
        addr_in        = a;
        out_port_ready = rdy;
        #2;
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 3'b000, 16'h0000, 3'd0, 1'b0);
        step(); step();
        rst = 1'b0;
        drive(1'b0, 3'b000, 16'h0000, 3'd0, 1'b0);
        n_checks++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL init_count: got %0d expected 0", out_count); end
        n_checks++; if (out_port_valid !== 1'b0) begin n_fail++; $display("FAIL init_valid: got %b expected 0", out_port_valid); end
        n_checks++; if (out_port_last !== 16'h0000) begin n_fail++; $display("FAIL init_last: got %h expected 0000", out_port_last); end
        n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL init_stall: got %b expected 0", wb_stall); end
        // Queue three entries, then reset mid-stream.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 3'b010, 16'(i), 3'd0, 1'b0);
            step();
        end
        drive(1'b0, 3'b000, 16'h0000, 3'd0, 1'b0);
        n_checks++; if (out_count !== 3'd3) begin n_fail++; $display("FAIL pre_rst_count: got %0d expected 3", out_count); end
        n_checks++; if (out_port_last !== 16'h0003) begin n_fail++; $display("FAIL pre_rst_last: got %h expected 0003", out_port_last); end
        rst = 1'b1;
        drive(1'b1, 3'b011, 16'h0055, 3'd1, 1'b0);
        n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL rst_reg_write: got %b expected 0", reg_write); end
        n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b expected 0", wb_stall); end
        step();
        rst = 1'b0;
        drive(1'b0, 3'b000, 16'h0000, 3'd0, 1'b0);
        n_checks++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", out_count); end
        n_checks++; if (out_port_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", out_port_valid); end
        n_checks++; if (out_port_last !== 16'h0000) begin n_fail++; $display("FAIL rst_last: got %h expected 0000", out_port_last); end
    endtask

    task automatic test_alu_writeback();
        drive(1'b1, 3'b001, 16'hBEEF, 3'd5, 1'b0);
        n_checks++; if (reg_write !== 1'b1) begin n_fail++; $display("FAIL alu_reg_write: got %b expected 1", reg_write); end
        n_checks++; if (write_addr !== 3'd5) begin n_fail++; $display("FAIL alu_addr: got %0d expected 5", write_addr); end
        n_checks++; if (write_data !== 16'hBEEF) begin n_fail++; $display("FAIL alu_data: got %h expected beef", write_data); end
        n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b expected 0", wb_stall); end
        step();
        // Reserved bit set alongside reg_write only: still a plain register write.
        drive(1'b1, 3'b101, 16'h1234, 3'd6, 1'b0);
        n_checks++; if (reg_write !== 1'b1) begin n_fail++; $display("FAIL rsvd_reg_write: got %b expected 1", reg_write); end
        step();
        drive(1'b0, 3'b000, 16'h0000, 3'd0, 1'b0);
        n_checks++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL alu_no_push: got %0d expected 0", out_count); end
        n_checks++; if (out_port_valid !== 1'b0) begin n_fail++; $display("FAIL alu_valid: got %b expected 0", out_port_valid); end
    endtask

    task automatic test_out_burst();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 3'b010, 16'(i), 3'(i), 1'b0);
            n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL burst_stall_%0d: got %b expected 0", i, wb_stall); end
            step();
        end
        // Fifth OUT (also requesting a register write) meets a full FIFO.
        drive(1'b1, 3'b011, 16'h0005, 3'd3, 1'b0);
        n_checks++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL burst_count: got %0d expected 4", out_count); end
        n_checks++; if (wb_stall !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b expected 1", wb_stall); end
        n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL full_reg_write: got %b expected 0", reg_write); end
        n_checks++; if (out_port_data !== 16'h0001) begin n_fail++; $display("FAIL full_head: got %h expected 0001", out_port_data); end
        step();
        n_checks++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL stalled_count: got %0d expected 4", out_count); end
        n_checks++; if (out_port_last !== 16'h0004) begin n_fail++; $display("FAIL stalled_last: got %h expected 0004", out_port_last); end
        // Ready for one cycle: pop happens, but the stalled push is not bypassed.
        drive(1'b1, 3'b011, 16'h0005, 3'd3, 1'b1);
        n_checks++; if (wb_stall !== 1'b1) begin n_fail++; $display("FAIL pop_cycle_stall: got %b expected 1", wb_stall); end
        n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL pop_cycle_reg_write: got %b expected 0", reg_write); end
        step();
        drive(1'b1, 3'b011, 16'h0005, 3'd3, 1'b0);
        n_checks++; if (out_count !== 3'd3) begin n_fail++; $display("FAIL after_pop_count: got %0d expected 3", out_count); end
        n_checks++; if (out_port_data !== 16'h0002) begin n_fail++; $display("FAIL after_pop_head: got %h expected 0002", out_port_data); end
        n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL retry_stall: got %b expected 0", wb_stall); end
        n_checks++; if (reg_write !== 1'b1) begin n_fail++; $display("FAIL retry_reg_write: got %b expected 1", reg_write); end
        step();
        drive(1'b0, 3'b000, 16'h0000, 3'd0, 1'b0);
        n_checks++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL retry_count: got %0d expected 4", out_count); end
        n_checks++; if (out_port_last !== 16'h0005) begin n_fail++; $display("FAIL retry_last: got %h expected 0005", out_port_last); end
        // Drain and confirm order 2,3,4,5.
        for (int k = 2; k <= 5; k++) begin
            drive(1'b0, 3'b000, 16'h0000, 3'd0, 1'b1);
            n_checks++; if (out_port_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid_%0d: got %b expected 1", k, out_port_valid); end
            n_checks++; if (out_port_data !== 16'(k)) begin n_fail++; $display("FAIL drain_head_%0d: got %h expected %h", k, out_port_data, 16'(k)); end
            step();
        end
        drive(1'b0, 3'b000, 16'h0000, 3'd0, 1'b0);
        n_checks++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL drained_count: got %0d expected 0", out_count); end
        n_checks++; if (out_port_valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid: got %b expected 0", out_port_valid); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'b010, 16'h0001, 3'd0, 1'b0);
        step();
        drive(1'b1, 3'b010, 16'h0002, 3'd0, 1'b0);
        step();
        // Steady push+pop at occupancy 2 across two full pointer wraps.
        for (int k = 3; k <= 10; k++) begin
            drive(1'b1, 3'b010, 16'(k), 3'd0, 1'b1);
            n_checks++; if (out_count !== 3'd2) begin n_fail++; $display("FAIL b2b_count_%0d: got %0d expected 2", k, out_count); end
            n_checks++; if (out_port_data !== 16'(k - 2)) begin n_fail++; $display("FAIL b2b_head_%0d: got %h expected %h", k, out_port_data, 16'(k - 2)); end
            n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_%0d: got %b expected 0", k, wb_stall); end
            step();
        end
        for (int k = 9; k <= 10; k++) begin
            drive(1'b0, 3'b000, 16'h0000, 3'd0, 1'b1);
            n_checks++; if (out_port_data !== 16'(k)) begin n_fail++; $display("FAIL b2b_tail_%0d: got %h expected %h", k, out_port_data, 16'(k)); end
            step();
        end
        drive(1'b0, 3'b000, 16'h0000, 3'd0, 1'b0);
        n_checks++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL b2b_end_count: got %0d expected 0", out_count); end
    endtask

    task automatic test_combined();
        drive(1'b1, 3'b011, 16'h00A5, 3'd2, 1'b0);
        n_checks++; if (reg_write !== 1'b1) begin n_fail++; $display("FAIL comb_reg_write: got %b expected 1", reg_write); end
        n_checks++; if (write_addr !== 3'd2) begin n_fail++; $display("FAIL comb_addr: got %0d expected 2", write_addr); end
        n_checks++; if (write_data !== 16'h00A5) begin n_fail++; $display("FAIL comb_data: got %h expected 00a5", write_data); end
        step();
        drive(1'b0, 3'b000, 16'h0000, 3'd0, 1'b0);
        n_checks++; if (out_port_last !== 16'h00A5) begin n_fail++; $display("FAIL comb_last: got %h expected 00a5", out_port_last); end
        n_checks++; if (out_count !== 3'd1) begin n_fail++; $display("FAIL comb_count: got %0d expected 1", out_count); end
        n_checks++; if (out_port_data !== 16'h00A5) begin n_fail++; $display("FAIL comb_head: got %h expected 00a5", out_port_data); end
    endtask

    task automatic test_invalid_slot();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 3'b010, 16'(16'hB0 + i), 3'd0, 1'b0);
            step();
        end
        drive(1'b0, 3'b011, 16'hDEAD, 3'd7, 1'b0);
        n_checks++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL inv_full_count: got %0d expected 4", out_count); end
        n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL inv_reg_write: got %b expected 0", reg_write); end
        n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL inv_stall: got %b expected 0", wb_stall); end
        step();
        drive(1'b0, 3'b011, 16'hDEAD, 3'd7, 1'b0);
        n_checks++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL inv_count_after: got %0d expected 4", out_count); end
        n_checks++; if (out_port_last !== 16'h00B3) begin n_fail++; $display("FAIL inv_last: got %h expected 00b3", out_port_last); end
        n_checks++; if (out_port_data !== 16'h00A5) begin n_fail++; $display("FAIL inv_head: got %h expected 00a5", out_port_data); end
    endtask

    initial begin
        test_reset();
        test_alu_writeback();
        test_out_burst();
        test_back_to_back();
        test_combined();
        test_invalid_slot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
